// File: rtl/sc_mult_scheduler.sv
// sc_mult_scheduler: two-requester round-robin scheduler for a stochastic-computing multiplier.
// Each job counts the ones of an AND/XNOR product stream built from two LFSR comparators.
module sc_mult_scheduler #(
  parameter logic [30:0] SEED_A = 31'd1,
  parameter logic [30:0] SEED_B = 31'd2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req_valid,
  output logic [1:0] req_ready,
  input  logic [7:0] req_a,
  input  logic [7:0] req_b,
  input  logic [3:0] req_len,
  input  logic [1:0] req_mode,
  output logic       res_valid,
  input  logic       res_ready,
  output logic [6:0] res_count,
  output logic       res_id,
  output logic       busy
);
  typedef enum logic [1:0] {IDLE, SEED, RUN, DONE} state_t;
  state_t state;
  logic prio, gnt, mode, sn_a, sn_b, prod;
  logic [3:0] a, b;
  logic [1:0] len;
  logic [30:0] lfsr_a, lfsr_b;
  logic [6:0] bit_cnt;
  // prio names the requester that wins a tie
  assign gnt = &req_valid ? prio : req_valid[1];
  assign req_ready = (state == IDLE && !rst_n && |req_valid) ? (gnt ? 2'b10 : 2'b01) : 2'b00;
  assign sn_a = lfsr_a[3:0] < a;
  assign sn_b = lfsr_b[3:0] < b;
  assign prod = mode ? ~(sn_a ^ sn_b) : sn_a & sn_b;
  assign busy = state != IDLE;
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state <= IDLE;
      prio <= 1'b0;
      res_valid <= 1'b0;
      res_count <= 7'd0;
      res_id <= 1'b0;
      lfsr_a <= SEED_A;
      lfsr_b <= SEED_B;
      bit_cnt <= 7'd0;
      a <= 4'd0;
      b <= 4'd0;
      len <= 2'd0;
      mode <= 1'b0;
    end else begin
      case (state)
        IDLE: if (|req_ready) begin
          a <= gnt ? req_a[7:4] : req_a[3:0];
          b <= gnt ? req_b[7:4] : req_b[3:0];
          len <= gnt ? req_len[3:2] : req_len[1:0];
          mode <= req_mode[gnt];
          res_id <= gnt;
          prio <= ~gnt;
          state <= SEED;
        end
        SEED: begin
          lfsr_a <= SEED_A;
          lfsr_b <= SEED_B;
          bit_cnt <= 7'd0;
          res_count <= 7'd0;
          state <= RUN;
        end
        RUN: begin
          lfsr_a <= {lfsr_a[29:0], lfsr_a[30] ^ lfsr_a[27]};
          lfsr_b <= {lfsr_b[29:0], lfsr_b[30] ^ lfsr_b[27]};
          bit_cnt <= bit_cnt + 7'd1;
          res_count <= res_count + {6'd0, prod};
          if (bit_cnt == (7'd8 << len) - 7'd1) begin
            state <= DONE;
            res_valid <= 1'b1;
          end
        end
        DONE: if (res_ready) begin
          state <= IDLE;
          res_valid <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_sc_mult_scheduler.sv
// tb_sc_mult_scheduler: directed and random jobs checked each cycle against a job-timeline model.
module tb_sc_mult_scheduler;
  logic clk = 0, rst_n = 1, res_ready = 0;
  logic [1:0] req_valid = 0, req_ready, req_mode = 0;
  logic [7:0] req_a = 0, req_b = 0;
  logic [3:0] req_len = 0;
  logic res_valid, res_id, busy;
  logic [6:0] res_count;
  int total = 0, bad = 0;
  int cyc = 0, k = 0, m_n = 8, m_exp = 0;
  logic m_active = 0, m_prio = 0, m_id = 0;

  always #5 clk = ~clk;

  sc_mult_scheduler dut (.clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_len(req_len), .req_mode(req_mode), .res_valid(res_valid),
    .res_ready(res_ready), .res_count(res_count), .res_id(res_id), .busy(busy));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
    end
  endtask

  function automatic int job_count(input logic [3:0] a, input logic [3:0] b, input logic [1:0] len, input logic m);
    logic [30:0] la = 31'd1, lb = 31'd2;
    int ones = 0;
    for (int i = 0; i < (8 << len); i++) begin
      logic sa, sb;
      sa = la[3:0] < a;
      sb = lb[3:0] < b;
      ones += m ? int'(sa == sb) : int'(sa && sb);
      la = {la[29:0], la[30] ^ la[27]};
      lb = {lb[29:0], lb[30] ^ lb[27]};
    end
    return ones;
  endfunction

  // Job-level model: a job accepted at edge k is in SEED, RUN for N edges, then DONE until res_ready
  always @(posedge clk) begin
    if (rst_n) begin
      m_active = 0;
      m_prio = 0;
    end else if (!m_active) begin
      if (|req_valid) begin
        logic g;
        g = &req_valid ? m_prio : req_valid[1];
        m_active = 1;
        k = cyc + 1;
        m_id = g;
        m_prio = ~g;
        m_n = 8 << (g ? req_len[3:2] : req_len[1:0]);
        m_exp = job_count(g ? req_a[7:4] : req_a[3:0], g ? req_b[7:4] : req_b[3:0],
                          g ? req_len[3:2] : req_len[1:0], req_mode[g]);
      end
    end else if (cyc - k >= m_n + 1 && res_ready) m_active = 0;
    cyc++;
  end

  always @(negedge clk) if (cyc > 0) begin
    logic ev, g;
    logic [1:0] er;
    ev = m_active && (cyc - k >= m_n + 1);
    g = &req_valid ? m_prio : req_valid[1];
    er = (!m_active && !rst_n && |req_valid) ? (g ? 2'b10 : 2'b01) : 2'b00;
    chk("busy", {31'd0, busy}, {31'd0, m_active});
    chk("res_valid", {31'd0, res_valid}, {31'd0, ev});
    chk("req_ready", {30'd0, req_ready}, {30'd0, er});
    if (ev) begin
      chk("res_count", {25'd0, res_count}, m_exp);
      chk("res_id", {31'd0, res_id}, {31'd0, m_id});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic go(input logic i, input logic [3:0] a, input logic [3:0] b, input logic [1:0] len, input logic m);
    req_a = {a, a};
    req_b = {b, b};
    req_len = {len, len};
    req_mode = {m, m};
    req_valid = i ? 2'b10 : 2'b01;
    step();
    req_valid = 2'b00;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!res_valid && lat < 200) begin
      step();
      lat++;
    end
    if (!res_valid) chk("res_valid_timeout", 0, 1);
  endtask

  initial begin
    int lat, c0, n, guard;
    logic ids [4];
    #1;
    req_valid = 2'b11;
    step();
    step();
    chk("rst_res_valid", {31'd0, res_valid}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_req_ready", {30'd0, req_ready}, 0);
    chk("rst_res_count", {25'd0, res_count}, 0);
    req_valid = 2'b00;
    rst_n = 0;
    chk("model_a0", job_count(4'd0, 4'd15, 2'd0, 1'b0), 0);
    chk("model_bipolar_zero", job_count(4'd0, 4'd0, 2'd3, 1'b1), 64);
    res_ready = 1;
    step();
    go(0, 4'd0, 4'd15, 2'd0, 0);
    wait_valid(lat);
    chk("lat_len0", lat, 9);
    chk("a0_count", {25'd0, res_count}, 0);
    chk("a0_id", {31'd0, res_id}, 0);
    step();
    go(0, 4'd0, 4'd15, 2'd0, 0);
    wait_valid(lat);
    chk("a0_repeat", {25'd0, res_count}, 0);
    step();
    go(0, 4'd9, 4'd7, 2'd1, 0);
    wait_valid(lat);
    c0 = int'(res_count);
    chk("job_model", c0, job_count(4'd9, 4'd7, 2'd1, 1'b0));
    step();
    go(1, 4'd9, 4'd7, 2'd1, 0);
    wait_valid(lat);
    chk("job_repeat", {25'd0, res_count}, c0);
    step();
    go(1, 4'd0, 4'd0, 2'd3, 1);
    wait_valid(lat);
    chk("lat_len3", lat, 65);
    chk("bip_count", {25'd0, res_count}, 64);
    chk("bip_id", {31'd0, res_id}, 1);
    step();
    res_ready = 0;
    go(0, 4'd9, 4'd7, 2'd1, 0);
    wait_valid(lat);
    req_valid = 2'b11;
    repeat (5) begin
      step();
      chk("stall_busy", {31'd0, busy}, 1);
      chk("stall_ready", {30'd0, req_ready}, 0);
    end
    req_valid = 2'b00;
    res_ready = 1;
    step();
    rst_n = 1;
    step();
    rst_n = 0;
    req_len = 4'd0;
    req_valid = 2'b11;
    n = 0;
    guard = 0;
    while (n < 4 && guard < 400) begin
      step();
      guard++;
      if (res_valid) begin
        ids[n] = res_id;
        n++;
      end
    end
    req_valid = 2'b00;
    chk("rr_results", n, 4);
    for (int i = 0; i < n; i++) chk("rr_id", {31'd0, ids[i]}, i % 2);
    step();
    go(1, 4'd5, 4'd11, 2'd2, 1);
    repeat (6) step();
    rst_n = 1;
    step();
    chk("midrun_busy", {31'd0, busy}, 0);
    rst_n = 0;
    repeat (40) step();
    go(0, 4'd12, 4'd3, 2'd2, 0);
    wait_valid(lat);
    chk("after_rst_count", {25'd0, res_count}, job_count(4'd12, 4'd3, 2'd2, 1'b0));
    step();
    repeat (3000) begin
      req_valid = 2'($urandom);
      req_a = 8'($urandom);
      req_b = 8'($urandom);
      req_len = 4'($urandom);
      req_mode = 2'($urandom);
      res_ready = ($urandom % 4) != 0;
      rst_n = ($urandom % 400) == 0;
      step();
    end
    rst_n = 0;
    req_valid = 2'b00;
    res_ready = 1;
    repeat (80) step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
